// File: rtl/pc_bcd_converter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_bcd_converter_if                                             |
// | Brief    : PC-in / BCD-digits-out bundle between datapath and display      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface pc_bcd_converter_if #(
    parameter int IN_WIDTH = 10
);
    logic [IN_WIDTH-1:0] pc_in;
    logic                start;
    logic                busy;
    logic                done;
    logic [3:0]          digit_tens;
    logic [3:0]          digit_ones;
    logic                overflow;

    modport master (
        output pc_in, start,
        input  busy, done, digit_tens, digit_ones, overflow
    );

    modport slave (
        input  pc_in, start,
        output busy, done, digit_tens, digit_ones, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_bcd_converter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_bcd_converter                                                |
// | Brief    : Word-index of the PC to two BCD digits by double dabble         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pc_bcd_converter #(
    parameter int IN_WIDTH = 10,
    parameter int SHIFT    = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pc_bcd_converter_if.slave  bus
);
    localparam int c_width = IN_WIDTH - SHIFT;
    localparam logic [4:0] c_last = 5'(c_width - 1);

    generate
        if (c_width < 1 || c_width > 16) begin : g_width_bad
            $error("pc_bcd_converter: IN_WIDTH - SHIFT must be within 1..16");
        end
        if (SHIFT > 0) begin : g_unused_low
            logic w_unused_low;
            assign w_unused_low = ^bus.pc_in[SHIFT-1:0];
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_width-1:0]   r_bin;
    logic [19:0]          r_bcd;
    logic [4:0]           r_count;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overflow;
    logic [3:0]           r_tens;
    logic [3:0]           r_ones;

    logic [19:0]          w_adj;
    logic [19:0]          w_next_bcd;
    logic                 w_unused_msb;

    // All five digits are corrected from the pre-shift value before the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < 5; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_next_bcd   = {w_adj[18:0], r_bin[c_width-1]};
    assign w_unused_msb = w_adj[19];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bin   <= bus.pc_in[IN_WIDTH-1:SHIFT];
                        r_bcd   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= w_next_bcd;
                    r_bin   <= r_bin << 1;
                    r_count <= r_count + 5'd1;
                    if (r_count == c_last) begin
                        // Digits update only here, so the decoder never sees scratch values.
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        if (w_next_bcd[19:8] == 12'd0) begin
                            r_overflow <= 1'b0;
                            r_tens     <= w_next_bcd[7:4];
                            r_ones     <= w_next_bcd[3:0];
                        end else begin
                            r_overflow <= 1'b1;
                            r_tens     <= 4'hF;
                            r_ones     <= 4'hF;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.digit_tens = r_tens;
    assign bus.digit_ones = r_ones;
    assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_pc_bcd_converter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pc_bcd_converter                                             |
// | Brief    : Directed vectors with a result queue checked on each done pulse |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pc_bcd_converter;
    localparam int c_lat = 8;   // edges from start acceptance to the done cycle

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       ovf;
        int         at;
    } exp_t;

    exp_t sb[$];

    pc_bcd_converter_if #(.IN_WIDTH(10)) bus ();

    pc_bcd_converter #(.IN_WIDTH(10), .SHIFT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.at);
                check("tens", int'(bus.digit_tens), int'(e.tens));
                check("ones", int'(bus.digit_ones), int'(e.ones));
                check("overflow", int'(bus.overflow), int'(e.ovf));
                check("busy_in_done", int'(bus.busy), 1);
            end
        end
    end

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic convert(input logic [9:0] pc, input logic [3:0] t,
                           input logic [3:0] o, input logic v);
        @(negedge clk);
        bus.pc_in = pc;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{t, o, v, cyc + c_lat});
        bus.start = 1'b0;
        bus.pc_in = ~pc;
        wait_done();
        @(negedge clk);
        check("busy_after_done", int'(bus.busy), 0);
        check("done_after_done", int'(bus.done), 0);
    endtask

    initial begin
        int n0;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.pc_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_digits", int'({bus.digit_tens, bus.digit_ones}), 8'h00);
        check("rst_overflow", int'(bus.overflow), 0);
        rst_n = 1'b1;

        convert(10'h05C, 4'd2, 4'd3, 1'b0);
        convert(10'h18C, 4'd9, 4'd9, 1'b0);
        convert(10'h190, 4'hF, 4'hF, 1'b1);
        convert(10'h3FF, 4'hF, 4'hF, 1'b1);
        convert(10'h003, 4'd0, 4'd0, 1'b0);

        // start held high with pc_in toggling: first index 9, then 255 sampled after done.
        @(negedge clk);
        bus.pc_in = 10'h024;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        sb.push_back('{4'd0, 4'd9, 1'b0, n0 + c_lat});
        sb.push_back('{4'hF, 4'hF, 1'b1, n0 + c_lat + 10});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.pc_in = k[0] ? 10'h3FF : 10'h000;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        check("held_queue_drained", sb.size(), 0);

        // Result 4/2 then a long idle stretch.
        convert(10'h0A8, 4'd4, 4'd2, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_hold", int'({bus.busy, bus.done, bus.digit_tens, bus.digit_ones, bus.overflow}),
                  int'({1'b0, 1'b0, 4'd4, 4'd2, 1'b0}));
        end

        // Abort on the 4th SHIFT cycle; no done may follow.
        @(negedge clk);
        bus.pc_in = 10'h05C;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_digits", int'({bus.digit_tens, bus.digit_ones}), 8'h00);
        check("abort_overflow", int'(bus.overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("final_queue_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/pc_bcd_converter.md
Name: pc_bcd_converter

Overview:
- Sequential binary-to-BCD converter sitting directly upstream of the two-digit seven-segment decoder on the FPGA board.
- Takes the datapath program counter, drops the word-alignment bits to get the instruction index, and converts it by iterative shift-add-3 (double dabble).
- Presents a stable tens digit and ones digit to the decoder.
- Values above 99 are flagged, and both digits are forced to 4'hF, which the decoder renders as blank.

Parameters:
- IN_WIDTH, 10, width of pc_in.
- SHIFT, 2, number of low pc_in bits discarded (byte address to instruction index).
- Derived W = IN_WIDTH - SHIFT; legal range 1..16 (violation is a synthesis-time error).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- pc_in  input  IN_WIDTH  program counter value; sampled only when a start is accepted.
- start  input  1  conversion request; level-sampled.
- busy  output  1  high while a conversion is in progress (states SHIFT and DONE).
- done  output  1  one-cycle pulse; digit outputs are valid and updated in that cycle.
- digit_tens  output  4  BCD tens digit, connects to the decoder's upper digit input.
- digit_ones  output  4  BCD ones digit, connects to the decoder's lower digit input.
- overflow  output  1  instruction index of the last conversion exceeded 99.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - State becomes IDLE.
  - busy=0, done=0, overflow=0, digit_tens=0, digit_ones=0 (display shows "00").
  - Counter and scratch registers are cleared.
  - Reset overrides any other input in the same cycle and aborts an in-flight conversion; no done pulse follows.
- IDLE:
  - start=1 at an edge → bin_reg <= pc_in[IN_WIDTH-1:SHIFT], bcd scratch (5 digits, 20 bits) <= 0, count <= 0, go to SHIFT.
  - start=0 → stay in IDLE.
  - Outputs hold their last values.
- SHIFT:
  - Each cycle, every scratch digit >= 5 gets +3 (all digits corrected in parallel, from the pre-shift value).
  - {scratch, bin_reg} is then shifted left by 1; count++.
  - After exactly W SHIFT cycles (count reaches W), go to DONE.
  - start is ignored; pc_in changes have no effect.
- DONE (exactly one cycle):
  - done=1.
  - digit_tens/digit_ones/overflow were loaded on entry edge, so they are valid in this cycle.
  - Then go to IDLE unconditionally; start in the DONE cycle is ignored.
- Output load rule:
  - If scratch digits 2..4 are all zero → overflow=0, digit_tens=scratch[7:4], digit_ones=scratch[3:0].
  - Otherwise → overflow=1, digit_tens=4'hF, digit_ones=4'hF.
- Latency: start sampled at edge N → done=1 during cycle N+W+1. Defaults: W=8, 9 cycles.
- Throughput: next start can be accepted at the edge ending the done cycle +1, i.e. one conversion per W+2 cycles when start is held high.
- busy: low in IDLE, high in SHIFT and DONE. done is never high outside DONE.
- Digit outputs change only on the DONE-entry edge or on reset, so the downstream decoder never sees intermediate scratch values.
- Bits of pc_in below SHIFT never influence results; unaligned PCs truncate.

Test Plan:
- Reset, then start with pc_in=10'h05C (index 23) → done high exactly 9 cycles after start; tens=2, ones=3, overflow=0, busy low the following cycle.
- pc_in=10'h18C (index 99) → tens=9, ones=9, overflow=0. Then pc_in=10'h190 (index 100) → overflow=1, tens=4'hF, ones=4'hF.
- pc_in=10'h3FF (index 255, low bits set) → overflow=1, digits 4'hF. Then pc_in=10'h003 → index 0, tens=0, ones=0, overflow cleared.
- Start held high, pc_in toggled every cycle during conversion of 10'h024 (index 9) → result tens=0, ones=9; next conversion begins in the IDLE cycle after done, done pulses spaced 10 cycles apart.
- rst_n=0 on 4th SHIFT cycle of a conversion → next cycle busy=0, digits 0, overflow 0; no done pulse ever appears for the aborted request.
- Idle with start=0 for 50 cycles after a result of 4/2 → outputs stay 4/2, done stays 0, busy stays 0.
